// File: rtl/rx_pkg.sv
// Shared definitions for the receive-frame arbiter.
//   - FSM state encodings (legacy 2-bit constants)
//   - default inter-frame gap and maximum frame length
//   - counter and index widths used by the top level and rr_pick
package rx_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PASS  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam int unsigned IFG_DEFAULT     = 12;
    localparam int unsigned MAX_LEN_DEFAULT = 2047;

    localparam int unsigned LEN_W = 12;   // frame length counter width
    localparam int unsigned GAP_W = 8;    // inter-frame gap counter width
    localparam int unsigned IDX_W = 2;    // stream index width (up to 4 streams)

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker.
// Ports:
//   req_i   - one request bit per stream
//   last_i  - index of the most recently granted stream
//   grant_o - one-hot grant, first requester at or after last_i+1 (wrapping)
//   valid_o - high when any request was granted
module rr_pick
    import rx_pkg::*;
#(
    parameter int unsigned N_PORTS = 3
) (
    input  logic [N_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [N_PORTS-1:0] grant_o,
    output logic               valid_o
);

    always_comb begin
        int unsigned idx;
        idx     = 0;
        grant_o = '0;
        valid_o = 1'b0;
        // Walk the streams in priority order starting just after last_i.
        for (int unsigned k = 1; k <= N_PORTS; k++) begin
            idx = int'(unsigned'(last_i)) + k;
            if (idx >= N_PORTS) begin
                idx = idx - N_PORTS;
            end
            for (int unsigned j = 0; j < N_PORTS; j++) begin
                if (!valid_o && idx == j && req_i[j]) begin
                    grant_o[j] = 1'b1;
                    valid_o    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rx_frame_arbiter.sv
// Receive-frame arbiter: forwards one filtered byte stream at a time to a
// single output, chosen round-robin among streams that start a frame while
// the arbiter is idle, with a minimum idle gap between granted frames and a
// maximum forwarded length.
// Ports:
//   clk       - single clock
//   rst       - asynchronous reset, active low
//   in_data   - one byte per stream, stream i at [8i+7:8i]
//   in_en     - per-stream frame-valid
//   port_mask - per-stream grant eligibility (0 = frames dropped)
//   data_out  - forwarded byte (0 whenever en_out is low)
//   en_out    - forwarded frame-valid, one cycle behind the input
//   sel_id    - index of the current/last granted stream
//   drop      - per-stream pulse in the cycle a frame start was not granted
//   overrun   - pulse when a granted frame is cut at MAX_LEN
module rx_frame_arbiter
    import rx_pkg::*;
#(
    parameter int unsigned N_PORTS    = 3,
    parameter int unsigned IFG_CYCLES = IFG_DEFAULT,
    parameter int unsigned MAX_LEN    = MAX_LEN_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*N_PORTS-1:0]   in_data,
    input  logic [N_PORTS-1:0]     in_en,
    input  logic [N_PORTS-1:0]     port_mask,
    output logic [7:0]             data_out,
    output logic                   en_out,
    output logic [IDX_W-1:0]       sel_id,
    output logic [N_PORTS-1:0]     drop,
    output logic                   overrun
);

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [N_PORTS-1:0] en_prev_q;
    logic               armed_q;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [7:0]         data_q, data_d;
    logic               en_q, en_d;
    logic               ovr_q, ovr_d;

    logic [N_PORTS-1:0] start;
    logic [N_PORTS-1:0] cand;
    logic [N_PORTS-1:0] grant;
    logic               grant_vld;
    logic [IDX_W-1:0]   gidx;
    logic [7:0]         gdata;
    logic               sel_en;
    logic [7:0]         sel_data;

    // armed_q stays low for the first cycle after reset so a stream that was
    // already mid-frame across reset is seen as a continuation, not a start.
    assign start = armed_q ? (in_en & ~en_prev_q) : '0;
    assign cand  = (state_q == ST_IDLE) ? (start & port_mask) : '0;

    rr_pick #(
        .N_PORTS (N_PORTS)
    ) u_pick (
        .req_i   (cand),
        .last_i  (last_q),
        .grant_o (grant),
        .valid_o (grant_vld)
    );

    // Every start that is not the winner is dropped; outside IDLE the grant
    // vector is all-zero so all starts drop.
    assign drop = start & ~grant;

    always_comb begin
        sel_en   = 1'b0;
        sel_data = '0;
        gidx     = '0;
        gdata    = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (sel_q == IDX_W'(i)) begin
                sel_en   = in_en[i];
                sel_data = in_data[8*i +: 8];
            end
            if (grant[i]) begin
                gidx  = IDX_W'(i);
                gdata = in_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        len_d   = len_q;
        gap_d   = gap_q;
        data_d  = '0;
        en_d    = 1'b0;
        ovr_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    last_d  = gidx;
                    sel_d   = gidx;
                    len_d   = LEN_W'(1);
                    en_d    = 1'b1;
                    data_d  = gdata;
                    state_d = ST_PASS;
                end
            end
            ST_PASS: begin
                if (!sel_en) begin
                    gap_d   = GAP_W'(IFG_CYCLES);
                    state_d = ST_GAP;
                end else if (len_q == LEN_W'(MAX_LEN)) begin
                    ovr_d   = 1'b1;
                    state_d = ST_DRAIN;
                end else begin
                    len_d  = len_q + LEN_W'(1);
                    en_d   = 1'b1;
                    data_d = sel_data;
                end
            end
            ST_DRAIN: begin
                if (!sel_en) begin
                    gap_d   = GAP_W'(IFG_CYCLES);
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                // Counter is loaded with IFG_CYCLES, so GAP lasts exactly
                // that many cycles before IDLE.
                if (gap_q <= GAP_W'(1)) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            last_q    <= IDX_W'(N_PORTS - 1);
            sel_q     <= '0;
            en_prev_q <= '0;
            armed_q   <= 1'b0;
            len_q     <= '0;
            gap_q     <= '0;
            data_q    <= '0;
            en_q      <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            sel_q     <= sel_d;
            en_prev_q <= in_en;
            armed_q   <= 1'b1;
            len_q     <= len_d;
            gap_q     <= gap_d;
            data_q    <= data_d;
            en_q      <= en_d;
            ovr_q     <= ovr_d;
        end
    end

    assign data_out = data_q;
    assign en_out   = en_q;
    assign sel_id   = sel_q;
    assign overrun  = ovr_q;

endmodule
